// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// serial_subtractor : bit-serial diff = a - b - borrow_in, LSB first, with a
// start/busy/done handshake. Define SUB_OVERFLOW_EN to enable the overflow flag.
// Revision 1.0
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic             br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_out_q, borrow_out_d;

  logic a_bit;
  logic b_bit;
  logic d_bit;
  logic br_next;
  logic load;
  logic last_step;

  assign a_bit   = ra_q[cnt_q];
  assign b_bit   = rb_q[cnt_q];
  assign d_bit   = a_bit ^ b_bit ^ br_q;
  assign br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);

  // Accept is possible both from IDLE and from the DONE cycle (back-to-back).
  assign load      = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_step = (state_q == S_RUN) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d      = state_q;
    ra_d         = ra_q;
    rb_d         = rb_q;
    br_d         = br_q;
    cnt_d        = cnt_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;

    if (load) begin
      ra_d         = a;
      rb_d         = b;
      br_d         = borrow_in;
      cnt_d        = '0;
      diff_d       = '0;
      borrow_out_d = 1'b0;
      state_d      = S_RUN;
    end else begin
      case (state_q)
        S_RUN: begin
          diff_d = {d_bit, diff_q[WIDTH-1:1]};
          br_d   = br_next;
          cnt_d  = cnt_q + CNT_W'(1);
          if (last_step) begin
            borrow_out_d = br_next;
            state_d      = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        S_IDLE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ra_q         <= '0;
      rb_q         <= '0;
      br_q         <= 1'b0;
      cnt_q        <= '0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ra_q         <= ra_d;
      rb_q         <= rb_d;
      br_q         <= br_d;
      cnt_q        <= cnt_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
    end
  end

`ifdef SUB_OVERFLOW_EN
  logic overflow_q, overflow_d;

  // On the last step the current operand bits are the sign bits.
  always_comb begin
    overflow_d = overflow_q;
    if (load) begin
      overflow_d = 1'b0;
    end else if (last_step) begin
      overflow_d = (a_bit != b_bit) && (d_bit != a_bit);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// Scoreboard bench for serial_subtractor: driver pushes model results, monitor
// pops and compares whenever done pulses.
module tb_serial_subtractor;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         borrow_in = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         overflow;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .borrow_in (borrow_in),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .borrow_out(borrow_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] diff;
    logic         bo;
    logic         ov;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic bin, input int dcyc);
    exp_t m;
    int   ua, ub, sa, sbv, r;
    ua    = int'(av);
    ub    = int'(bv);
    sa    = int'($signed(av));
    sbv   = int'($signed(bv));
    r     = sa - sbv - int'(bin);
    m.diff = W'(ua - ub - int'(bin));
    m.bo   = (ua < ub + int'(bin));
`ifdef SUB_OVERFLOW_EN
    m.ov   = (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
`else
    m.ov   = (r != r);
`endif
    m.cyc  = dcyc;
    return m;
  endfunction

  // Called on a negedge where the DUT is known to accept at the next edge.
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bin);
    a         = av;
    b         = bv;
    borrow_in = bin;
    start     = 1'b1;
    sb.push_back(model(av, bv, bin, cyc + 1 + W));
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 4 * W && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done, expected one within %0d cycles", 4 * W);
    end
  endtask

  // Monitor
  int   run_len   = 0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      check("busy_with_done", int'(busy), 0);
      check("done_one_cycle", int'(prev_done), 0);
      check("busy_cycles", run_len, W);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done, expected none (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("diff", int'(diff), int'(e.diff));
        check("borrow_out", int'(borrow_out), int'(e.bo));
        check("overflow", int'(overflow), int'(e.ov));
        check("done_cycle", cyc, e.cyc);
      end
      run_len = 0;
    end else if (busy) begin
      run_len++;
    end else begin
      run_len = 0;
    end
    prev_done = done;
  end

  initial begin
    bit chain;
    bit chain_next;

    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_diff", int'(diff), 0);
    check("rst_borrow_out", int'(borrow_out), 0);
    check("rst_overflow", int'(overflow), 0);
    reset = 1'b0;

    // 7 - 3
    @(negedge clk);
    launch(5'b00111, 5'b00011, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_done();
    check("t1_diff_const", int'(diff), 4);

    // 0 - 1
    @(negedge clk);
    launch(5'b00000, 5'b00001, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_done();
    check("t2_diff_const", int'(diff), 31);

    // start held high through RUN and DONE: chained second operation
    @(negedge clk);
    launch(5'b11111, 5'b11111, 1'b1);
    @(negedge clk);
    a         = 5'b01111;
    b         = 5'b00000;
    borrow_in = 1'b0;
    wait_done();
    launch(5'b01111, 5'b00000, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_done();
    check("t3_diff_const", int'(diff), 15);

    // Signed overflow case
    @(negedge clk);
    launch(5'b10000, 5'b00001, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // start pulses in RUN cycles 2 and 3 must be ignored
    @(negedge clk);
    launch(5'b01010, 5'b00011, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = W'($urandom); b = W'($urandom); borrow_in = 1'b1;
    @(negedge clk);
    start = 1'b1; a = W'($urandom); b = W'($urandom);
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Reset during RUN cycle 3 aborts the operation
    @(negedge clk);
    launch(5'b01001, 5'b00100, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_diff", int'(diff), 0);
    check("abort_borrow_out", int'(borrow_out), 0);
    sb.delete();
    reset = 1'b0;
    @(negedge clk);
    launch(5'b00110, 5'b00001, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_done();
    check("t6_diff_const", int'(diff), 5);

    // Randomized operations, some chained back-to-back
    chain = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (!chain) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
      end
      launch(W'($urandom), W'($urandom), 1'($urandom));
      chain_next = ($urandom_range(0, 1) == 1) && (i < 29);
      @(negedge clk);
      if (chain_next) begin
        a = W'($urandom);
        b = W'($urandom);
      end else begin
        start = 1'b0;
      end
      wait_done();
      chain = chain_next;
    end

    repeat (2 * W) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
